lsu: RTL and testbench
======================

# lsu

Load/store unit for the rv32i pipelined core. It sits after the ALU in the MEM stage and takes the ALU result as the effective address. For loads and stores it runs one data-memory transaction over a req/ack bus, with byte-lane steering and load extension. All other instructions pass through to writeback unchanged. There is one operation in flight at a time; upstream stalls on `req_ready`.

## Interface
- ADDR_W, 32, address width on the data-memory bus (data fixed at 32 bits)
- clk  in  1  core clock, rising edge
- r  in  1  reset, asynchronous, active-low (0 = reset)
- req_valid  in  1  EX/MEM register presents an instruction
- req_ready  out  1  unit can accept this cycle
- op_code  in  7  instruction opcode
- func_code  in  10  {f3, f7}; only f3 = func_code[9:7] is used
- alu_result  in  32  effective address (memory ops) or result (others)
- store_data  in  32  rs2 value
- rd_in  in  5  destination register
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  transaction complete; rdata valid the same cycle for reads
- dmem_rdata  in  32  read word
- wb_valid  out  1  one-cycle completion pulse
- wb_we  out  1  write wb_data to wb_rd
- wb_rd  out  5  destination register
- wb_data  out  32  result
- misaligned  out  1  pulses with wb_valid on a misaligned access

## Operation
- Accept when req_valid && req_ready. All inputs are captured into registers on accept.
- Load: op_code 0000011, f3 ∈ {lb 000, lh 001, lw 010, lbu 100, lhu 101}.
- Store: op_code 0100011, f3 ∈ {sb 000, sh 001, sw 010}.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00. A misaligned access issues no bus cycle, and completes with wb_we=0 and misaligned=1.
- Load or store with an unsupported f3: no bus cycle, wb_we=0, misaligned=0.
- Store steering:
  - sb: be = 0001 << addr[1:0], wdata = {4{sd[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
  - sw: be = 1111, wdata = sd.
- Load extraction: the selected byte/half is taken from the rdata lane given by addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw takes the full word.
  - Loads always read with be=1111.
- Completion values:
  - Load: wb_we=1, wb_data = extracted value.
  - Store: wb_we=0, wb_data=0.
  - Non-memory op: wb_we=1, wb_data = alu_result.
  - wb_rd = captured rd_in in all cases.
- State machine:
  - IDLE: req_ready=1. On accept, go to BUS for an aligned, supported memory op; otherwise go to RESP.
  - BUS: dmem_req=1 with addr/be/wdata/we stable. On dmem_ack, capture read data and go to RESP; otherwise stay.
  - RESP: wb_valid=1 for this cycle only, then IDLE.
- dmem_ack is ignored outside BUS.

## Timing
- Reset value 0 for every output: req_ready, dmem_*, wb_*, misaligned. State is IDLE.
- The first clk after r deasserts has req_ready=1.
- Latency from accept at edge N:
  - Non-memory or faulting op: wb_valid during cycle N+1.
  - Memory op: dmem_req rises in cycle N+1. With ack during BUS cycle N+k (k ≥ 1), wb_valid is in cycle N+k+1.
- Peak throughput: one instruction every 2 cycles, or every 3 cycles for a zero-wait memory op.
- dmem_req deasserts in the cycle after the ack; there is no back-to-back bus request.
- Reset during BUS drops dmem_req asynchronously and clears all outputs. A late ack after reset is ignored.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Add to defines.v:
  - op_load and op_store opcodes.
  - Store f3 constants f3_sb/f3_sh/f3_sw (already present). Load f3 constants (already present).
  - State encodings LSU_IDLE/LSU_BUS/LSU_RESP.
- Sub-module `lsu_align`: combinational. Maps (f3, addr[1:0], store_data, rdata) to (be, wdata, load_value, misaligned). The FSM lives in `lsu`.

## Test plan
- Non-memory pass-through: op_code 0110011, alu_result=0x1234_5678, rd=5 → wb_valid in N+1, wb_we=1, wb_data=0x1234_5678, wb_rd=5, no dmem_req.
- sb: addr 0x1003, sd 0xAABB_CCDD, ack immediate → dmem_addr 0x1000, be 1000, wdata 0xDDDD_DDDD, we=1; wb_valid in N+2 with wb_we=0.
- lb/lbu: addr 0x2001, rdata 0x0000_8000 → lb gives wb_data 0xFFFF_FF80; lbu gives 0x0000_0080.
- Wait states: lw at 0x3000, ack held low 3 BUS cycles → dmem_req high for 4 cycles with stable outputs, req_ready=0 throughout, one wb_valid.
- Misaligned: lw at 0x4002 or sh at 0x4001 → no dmem_req, misaligned=1 with wb_valid in N+1, wb_we=0.
- Reset mid-BUS: assert r=0 during BUS → dmem_req falls without waiting for a clk edge. Ack pulsed after release → no wb_valid, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared opcodes, funct3 encodings and FSM state type for the rv32i load/store unit.
package lsu_pkg;

    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;

    localparam logic [2:0] f3_lb  = 3'b000;
    localparam logic [2:0] f3_lh  = 3'b001;
    localparam logic [2:0] f3_lw  = 3'b010;
    localparam logic [2:0] f3_lbu = 3'b100;
    localparam logic [2:0] f3_lhu = 3'b101;

    localparam logic [2:0] f3_sb  = 3'b000;
    localparam logic [2:0] f3_sh  = 3'b001;
    localparam logic [2:0] f3_sw  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    // func_code is packed as {f3, f7}.
    function automatic logic [2:0] get_f3(input logic [9:0] func_code);
        return func_code[9:7];
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory req/ack bus between the load/store unit (master) and memory (slave).
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores, lane extraction/extension for loads,
// and alignment / funct3 legality decode.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  f3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic        misaligned,
    output logic        f3_ok
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be         = 4'b1111;
        wdata      = '0;
        misaligned = 1'b0;
        f3_ok      = 1'b0;
        if (is_store) begin
            case (f3)
                f3_sb: begin
                    f3_ok = 1'b1;
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                f3_sh: begin
                    f3_ok      = 1'b1;
                    misaligned = addr_lo[0];
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata      = {2{store_data[15:0]}};
                end
                f3_sw: begin
                    f3_ok      = 1'b1;
                    misaligned = |addr_lo;
                    wdata      = store_data;
                end
                default: f3_ok = 1'b0;
            endcase
        end else begin
            // Loads always fetch the whole word; the lane is picked on return.
            case (f3)
                f3_lb, f3_lbu: f3_ok = 1'b1;
                f3_lh, f3_lhu: begin
                    f3_ok      = 1'b1;
                    misaligned = addr_lo[0];
                end
                f3_lw: begin
                    f3_ok      = 1'b1;
                    misaligned = |addr_lo;
                end
                default: f3_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_value = '0;
        case (f3)
            f3_lb:   load_value = {{24{byte_sel[7]}}, byte_sel};
            f3_lbu:  load_value = {24'd0, byte_sel};
            f3_lh:   load_value = {{16{half_sel[15]}}, half_sel};
            f3_lhu:  load_value = {16'd0, half_sel};
            f3_lw:   load_value = rdata;
            default: load_value = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one req/ack data-memory transaction per load/store,
// pass-through for every other instruction, one operation in flight at a time.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        r,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  op_code,
    input  logic [9:0]  func_code,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    lsu_if.master       dmem,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned
);

    lsu_state_t state, state_n;

    logic [2:0] f3_q, f3_n;
    logic [1:0] addr_lo_q, addr_lo_n;
    logic       is_store_q, is_store_n;
    logic [4:0] rd_q, rd_n;

    logic              req_ready_n;
    logic              dmem_req_n;
    logic              dmem_we_n;
    logic [ADDR_W-1:0] dmem_addr_n;
    logic [3:0]        dmem_be_n;
    logic [31:0]       dmem_wdata_n;
    logic              wb_valid_n;
    logic              wb_we_n;
    logic [4:0]        wb_rd_n;
    logic [31:0]       wb_data_n;
    logic              misaligned_n;

    logic        in_is_load;
    logic        in_is_store;
    logic        al_is_store;
    logic [2:0]  al_f3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load_value;
    logic        al_misaligned;
    logic        al_f3_ok;
    logic        unused_func;

    assign unused_func = ^func_code[6:0];
    assign in_is_load  = (op_code == op_load);
    assign in_is_store = (op_code == op_store);

    // In IDLE the aligner decodes the incoming request; afterwards it works
    // from the captured copy so the load lane can be selected at ack time.
    assign al_is_store = (state == LSU_IDLE) ? in_is_store : is_store_q;
    assign al_f3       = (state == LSU_IDLE) ? get_f3(func_code) : f3_q;
    assign al_addr_lo  = (state == LSU_IDLE) ? alu_result[1:0] : addr_lo_q;

    lsu_align u_align (
        .is_store   (al_is_store),
        .f3         (al_f3),
        .addr_lo    (al_addr_lo),
        .store_data (store_data),
        .rdata      (dmem.dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_value (al_load_value),
        .misaligned (al_misaligned),
        .f3_ok      (al_f3_ok)
    );

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state           <= LSU_IDLE;
            f3_q            <= '0;
            addr_lo_q       <= '0;
            is_store_q      <= 1'b0;
            rd_q            <= '0;
            req_ready       <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= '0;
            dmem.dmem_wdata <= '0;
            wb_valid        <= 1'b0;
            wb_we           <= 1'b0;
            wb_rd           <= '0;
            wb_data         <= '0;
            misaligned      <= 1'b0;
        end else begin
            state           <= state_n;
            f3_q            <= f3_n;
            addr_lo_q       <= addr_lo_n;
            is_store_q      <= is_store_n;
            rd_q            <= rd_n;
            req_ready       <= req_ready_n;
            dmem.dmem_req   <= dmem_req_n;
            dmem.dmem_we    <= dmem_we_n;
            dmem.dmem_addr  <= dmem_addr_n;
            dmem.dmem_be    <= dmem_be_n;
            dmem.dmem_wdata <= dmem_wdata_n;
            wb_valid        <= wb_valid_n;
            wb_we           <= wb_we_n;
            wb_rd           <= wb_rd_n;
            wb_data         <= wb_data_n;
            misaligned      <= misaligned_n;
        end
    end

    // Every output is computed one cycle ahead here and registered above.
    always_comb begin
        state_n      = state;
        f3_n         = f3_q;
        addr_lo_n    = addr_lo_q;
        is_store_n   = is_store_q;
        rd_n         = rd_q;
        req_ready_n  = 1'b0;
        dmem_req_n   = dmem.dmem_req;
        dmem_we_n    = dmem.dmem_we;
        dmem_addr_n  = dmem.dmem_addr;
        dmem_be_n    = dmem.dmem_be;
        dmem_wdata_n = dmem.dmem_wdata;
        wb_valid_n   = 1'b0;
        wb_we_n      = 1'b0;
        wb_rd_n      = '0;
        wb_data_n    = '0;
        misaligned_n = 1'b0;

        case (state)
            LSU_IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_n = 1'b0;
                    f3_n        = get_f3(func_code);
                    addr_lo_n   = alu_result[1:0];
                    is_store_n  = in_is_store;
                    rd_n        = rd_in;
                    if ((in_is_load || in_is_store) && al_f3_ok && !al_misaligned) begin
                        state_n      = LSU_BUS;
                        dmem_req_n   = 1'b1;
                        dmem_we_n    = in_is_store;
                        dmem_addr_n  = {alu_result[ADDR_W-1:2], 2'b00};
                        dmem_be_n    = al_be;
                        dmem_wdata_n = al_wdata;
                    end else begin
                        state_n    = LSU_RESP;
                        wb_valid_n = 1'b1;
                        wb_rd_n    = rd_in;
                        if (in_is_load || in_is_store) begin
                            misaligned_n = al_f3_ok && al_misaligned;
                        end else begin
                            wb_we_n   = 1'b1;
                            wb_data_n = alu_result;
                        end
                    end
                end
            end
            LSU_BUS: begin
                if (dmem.dmem_ack) begin
                    state_n      = LSU_RESP;
                    dmem_req_n   = 1'b0;
                    dmem_we_n    = 1'b0;
                    dmem_addr_n  = '0;
                    dmem_be_n    = '0;
                    dmem_wdata_n = '0;
                    wb_valid_n   = 1'b1;
                    wb_rd_n      = rd_q;
                    wb_we_n      = !is_store_q;
                    wb_data_n    = is_store_q ? 32'd0 : al_load_value;
                end
            end
            LSU_RESP: begin
                state_n     = LSU_IDLE;
                req_ready_n = 1'b1;
            end
            default: begin
                state_n = LSU_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: reset, pass-through, stores, loads,
// wait states, faults, back-to-back issue and reset in the middle of a bus cycle.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        r;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  op_code;
    logic [9:0]  func_code;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    lsu_if #(.ADDR_W(32)) dmem_bus ();

    lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .r          (r),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_code    (op_code),
        .func_code  (func_code),
        .alu_result (alu_result),
        .store_data (store_data),
        .rd_in      (rd_in),
        .dmem       (dmem_bus),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd);
        op_code    = op;
        func_code  = {f3, 7'b0000000};
        alu_result = addr;
        store_data = sd;
        rd_in      = rd;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b0;
        tick();
        tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready got %b expected 0", req_ready); end
        checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_dmem_req got %b expected 0", dmem_bus.dmem_req); end
        checks++; if ({wb_valid, wb_we, misaligned} !== 3'b000) begin errors++; $display("[TB] FAIL reset_wb_flags got %b expected 000", {wb_valid, wb_we, misaligned}); end
        checks++; if (wb_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wb_data got %h expected 00000000", wb_data); end
        #3;
        r = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready got %b expected 1", req_ready); end
    endtask

    task automatic test_passthrough();
        issue(7'b0110011, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL pass_wb_valid got %b expected 1", wb_valid); end
        checks++; if (wb_we !== 1'b1) begin errors++; $display("[TB] FAIL pass_wb_we got %b expected 1", wb_we); end
        checks++; if (wb_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL pass_wb_data got %h expected 12345678", wb_data); end
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("[TB] FAIL pass_wb_rd got %0d expected 5", wb_rd); end
        checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL pass_dmem_req got %b expected 0", dmem_bus.dmem_req); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL pass_busy got %b expected 0", req_ready); end
        tick();
        checks++; if ({wb_valid, req_ready} !== 2'b01) begin errors++; $display("[TB] FAIL pass_after got %b expected 01", {wb_valid, req_ready}); end
    endtask

    task automatic test_stores();
        logic [2:0]  f3_t [3]  = '{f3_sb, f3_sh, f3_sw};
        logic [31:0] adr_t [3] = '{32'h0000_1003, 32'h0000_1002, 32'h0000_1004};
        logic [31:0] sd_t [3]  = '{32'hAABB_CCDD, 32'h1122_3344, 32'hCAFE_F00D};
        logic [31:0] exa_t [3] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004};
        logic [3:0]  exb_t [3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] exw_t [3] = '{32'hDDDD_DDDD, 32'h3344_3344, 32'hCAFE_F00D};
        for (int i = 0; i < 3; i++) begin
            issue(op_store, f3_t[i], adr_t[i], sd_t[i], 5'd7);
            checks++; if ({dmem_bus.dmem_req, dmem_bus.dmem_we} !== 2'b11) begin errors++; $display("[TB] FAIL store%0d_req_we got %b expected 11", i, {dmem_bus.dmem_req, dmem_bus.dmem_we}); end
            checks++; if (dmem_bus.dmem_addr !== exa_t[i]) begin errors++; $display("[TB] FAIL store%0d_addr got %h expected %h", i, dmem_bus.dmem_addr, exa_t[i]); end
            checks++; if (dmem_bus.dmem_be !== exb_t[i]) begin errors++; $display("[TB] FAIL store%0d_be got %b expected %b", i, dmem_bus.dmem_be, exb_t[i]); end
            checks++; if (dmem_bus.dmem_wdata !== exw_t[i]) begin errors++; $display("[TB] FAIL store%0d_wdata got %h expected %h", i, dmem_bus.dmem_wdata, exw_t[i]); end
            dmem_bus.dmem_ack = 1'b1;
            tick();
            dmem_bus.dmem_ack = 1'b0;
            checks++; if ({wb_valid, wb_we, dmem_bus.dmem_req} !== 3'b100) begin errors++; $display("[TB] FAIL store%0d_complete got %b expected 100", i, {wb_valid, wb_we, dmem_bus.dmem_req}); end
            checks++; if (wb_data !== 32'd0 || wb_rd !== 5'd7) begin errors++; $display("[TB] FAIL store%0d_wb got %h/%0d expected 00000000/7", i, wb_data, wb_rd); end
            tick();
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3_t [6]  = '{f3_lb, f3_lbu, f3_lh, f3_lhu, f3_lw, f3_lb};
        logic [31:0] adr_t [6] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2004, 32'h2003};
        logic [31:0] rd_t [6]  = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000,
                                  32'h8001_0000, 32'hDEAD_BEEF, 32'h7F00_0000};
        logic [31:0] exp_t [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                  32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_007F};
        for (int i = 0; i < 6; i++) begin
            issue(op_load, f3_t[i], adr_t[i], 32'hFFFF_FFFF, 5'd3);
            checks++; if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be} !== 6'b10_1111) begin errors++; $display("[TB] FAIL load%0d_req got %b expected 101111", i, {dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be}); end
            checks++; if (dmem_bus.dmem_addr !== {adr_t[i][31:2], 2'b00}) begin errors++; $display("[TB] FAIL load%0d_addr got %h expected %h", i, dmem_bus.dmem_addr, {adr_t[i][31:2], 2'b00}); end
            dmem_bus.dmem_ack   = 1'b1;
            dmem_bus.dmem_rdata = rd_t[i];
            tick();
            dmem_bus.dmem_ack   = 1'b0;
            dmem_bus.dmem_rdata = 32'h0;
            checks++; if ({wb_valid, wb_we} !== 2'b11) begin errors++; $display("[TB] FAIL load%0d_flags got %b expected 11", i, {wb_valid, wb_we}); end
            checks++; if (wb_data !== exp_t[i]) begin errors++; $display("[TB] FAIL load%0d_data got %h expected %h", i, wb_data, exp_t[i]); end
            tick();
        end
    endtask

    task automatic test_wait_states();
        int pulses = 0;
        issue(op_load, f3_lw, 32'h0000_3000, 32'h0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({dmem_bus.dmem_req, dmem_bus.dmem_we, req_ready, wb_valid} !== 4'b1000) begin errors++; $display("[TB] FAIL wait%0d_ctrl got %b expected 1000", i, {dmem_bus.dmem_req, dmem_bus.dmem_we, req_ready, wb_valid}); end
            checks++; if (dmem_bus.dmem_addr !== 32'h3000 || dmem_bus.dmem_be !== 4'b1111) begin errors++; $display("[TB] FAIL wait%0d_bus got %h/%b expected 00003000/1111", i, dmem_bus.dmem_addr, dmem_bus.dmem_be); end
            if (i == 3) begin
                dmem_bus.dmem_ack   = 1'b1;
                dmem_bus.dmem_rdata = 32'h0102_0304;
            end
            tick();
            if (wb_valid === 1'b1) pulses++;
        end
        dmem_bus.dmem_ack = 1'b0;
        checks++; if (wb_data !== 32'h0102_0304 || wb_rd !== 5'd9) begin errors++; $display("[TB] FAIL wait_data got %h/%0d expected 01020304/9", wb_data, wb_rd); end
        tick();
        if (wb_valid === 1'b1) pulses++;
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL wait_pulses got %0d expected 1", pulses); end
        checks++; if ({dmem_bus.dmem_req, req_ready} !== 2'b01) begin errors++; $display("[TB] FAIL wait_end got %b expected 01", {dmem_bus.dmem_req, req_ready}); end
    endtask

    task automatic test_faults();
        logic [6:0]  op_t [3]  = '{op_load, op_store, op_load};
        logic [2:0]  f3_t [3]  = '{f3_lw, f3_sh, 3'b011};
        logic [31:0] adr_t [3] = '{32'h4002, 32'h4001, 32'h4000};
        logic        mis_t [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            issue(op_t[i], f3_t[i], adr_t[i], 32'h5555_5555, 5'd11);
            checks++; if ({dmem_bus.dmem_req, wb_valid, wb_we} !== 3'b010) begin errors++; $display("[TB] FAIL fault%0d_ctrl got %b expected 010", i, {dmem_bus.dmem_req, wb_valid, wb_we}); end
            checks++; if (misaligned !== mis_t[i]) begin errors++; $display("[TB] FAIL fault%0d_misaligned got %b expected %b", i, misaligned, mis_t[i]); end
            tick();
            checks++; if ({misaligned, wb_valid, dmem_bus.dmem_req} !== 3'b000) begin errors++; $display("[TB] FAIL fault%0d_after got %b expected 000", i, {misaligned, wb_valid, dmem_bus.dmem_req}); end
        end
    endtask

    task automatic test_back_to_back();
        op_code    = 7'b0010011;
        func_code  = '0;
        alu_result = 32'h0000_00A1;
        rd_in      = 5'd1;
        req_valid  = 1'b1;
        tick();
        alu_result = 32'h0000_00B2;
        rd_in      = 5'd2;
        checks++; if (wb_data !== 32'hA1 || wb_rd !== 5'd1) begin errors++; $display("[TB] FAIL b2b_first got %h/%0d expected 000000a1/1", wb_data, wb_rd); end
        tick();
        checks++; if ({wb_valid, req_ready} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_gap got %b expected 01", {wb_valid, req_ready}); end
        tick();
        req_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hB2 || wb_rd !== 5'd2) begin errors++; $display("[TB] FAIL b2b_second got %b/%h/%0d expected 1/000000b2/2", wb_valid, wb_data, wb_rd); end
        tick();
    endtask

    task automatic test_reset_mid_bus();
        dmem_bus.dmem_ack = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack_ignored got %b expected 0", wb_valid); end
        issue(op_store, f3_sw, 32'h0000_5000, 32'h0BAD_CAFE, 5'd4);
        checks++; if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_bus_req got %b expected 1", dmem_bus.dmem_req); end
        #2;
        r = 1'b0;
        #1;
        checks++; if ({dmem_bus.dmem_req, dmem_bus.dmem_we, req_ready} !== 3'b000) begin errors++; $display("[TB] FAIL rst_async_drop got %b expected 000", {dmem_bus.dmem_req, dmem_bus.dmem_we, req_ready}); end
        #1;
        r = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        checks++; if ({wb_valid, dmem_bus.dmem_req, req_ready} !== 3'b001) begin errors++; $display("[TB] FAIL rst_late_ack got %b expected 001", {wb_valid, dmem_bus.dmem_req, req_ready}); end
        issue(7'b0110111, 3'b000, 32'h0000_7000, 32'h0, 5'd6);
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h7000) begin errors++; $display("[TB] FAIL rst_recover got %b/%h expected 1/00007000", wb_valid, wb_data); end
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        req_valid           = 1'b0;
        op_code             = '0;
        func_code           = '0;
        alu_result          = '0;
        store_data          = '0;
        rd_in               = '0;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        $display("[TB] starting lsu bench");
        test_reset();
        test_passthrough();
        test_stores();
        test_loads();
        test_wait_states();
        test_faults();
        test_back_to_back();
        test_reset_mid_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
